// File: rtl/axi3_intbus_bridge.sv
// AXI3 slave to simple internal register bus bridge: one transaction at a time,
// every burst treated as INCR over full 32-bit words, all responses OKAY.
module axi3_intbus_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 12
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [31:0]           awaddr,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   input  logic [ID_WIDTH-1:0]   wid,
   output logic                  bvalid,
   input  logic                  bready,
   output logic [1:0]            bresp,
   output logic [ID_WIDTH-1:0]   bid,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [31:0]           araddr,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [3:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic [ID_WIDTH-1:0]   rid,
   output logic                  rlast,
   output logic [ADDR_WIDTH-1:0] int_addr,
   output logic [31:0]           int_wdata,
   output logic                  int_wr,
   output logic                  int_rd,
   input  logic [31:0]           int_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_DATA  = 3'd1,
      WR_RESP  = 3'd2,
      RD_ISSUE = 3'd3,
      RD_WAIT  = 3'd4,
      RD_DATA  = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [ID_WIDTH-1:0]   id, id_nxt;
   logic [3:0]            beats, beats_nxt;
   logic [31:0]           rdata_q, rdata_nxt;
   logic                  unused_ok;

   // Size, burst type, strobes, wlast, wid and address bits outside the word window carry no meaning here.
   assign unused_ok = ^{awaddr, araddr, awsize, arsize, awburst, arburst, wstrb, wlast, wid};

   assign bresp     = 2'b00;
   assign rresp     = 2'b00;
   assign int_addr  = addr;
   assign rdata     = rdata_q;
   assign int_wdata = int_wr ? wdata : 32'd0;

   // State and transaction context registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         addr    <= '0;
         id      <= '0;
         beats   <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state   <= state_nxt;
         addr    <= addr_nxt;
         id      <= id_nxt;
         beats   <= beats_nxt;
         rdata_q <= rdata_nxt;
      end
   end

   // Next-state, context updates and channel handshake outputs.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      id_nxt    = id;
      beats_nxt = beats;
      rdata_nxt = rdata_q;
      awready   = 1'b0;
      arready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bid       = '0;
      rvalid    = 1'b0;
      rid       = '0;
      rlast     = 1'b0;
      int_wr    = 1'b0;
      int_rd    = 1'b0;
      case (state)
         IDLE: begin
            // Write wins when both address channels are valid together.
            if (awvalid) begin
               awready   = 1'b1;
               addr_nxt  = awaddr[ADDR_WIDTH+1:2];
               id_nxt    = awid;
               beats_nxt = awlen;
               state_nxt = WR_DATA;
            end else if (arvalid) begin
               arready   = 1'b1;
               addr_nxt  = araddr[ADDR_WIDTH+1:2];
               id_nxt    = arid;
               beats_nxt = arlen;
               state_nxt = RD_ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         WR_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               int_wr   = 1'b1;
               addr_nxt = addr + ADDR_WIDTH'(1);
               // Beat count alone ends the burst; wlast is not consulted.
               if (beats == 4'd0) begin
                  state_nxt = WR_RESP;
               end else begin
                  beats_nxt = beats - 4'd1;
               end
            end else begin
               state_nxt = WR_DATA;
            end
         end
         WR_RESP: begin
            bvalid = 1'b1;
            bid    = id;
            if (bready) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WR_RESP;
            end
         end
         RD_ISSUE: begin
            int_rd    = 1'b1;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            rdata_nxt = int_rdata;
            state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rvalid = 1'b1;
            rid    = id;
            rlast  = (beats == 4'd0);
            if (rready) begin
               if (beats == 4'd0) begin
                  state_nxt = IDLE;
               end else begin
                  addr_nxt  = addr + ADDR_WIDTH'(1);
                  beats_nxt = beats - 4'd1;
                  state_nxt = RD_ISSUE;
               end
            end else begin
               state_nxt = RD_DATA;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi3_intbus_bridge.sv
// Scoreboard bench for axi3_intbus_bridge: tasks queue expected bus/response
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_axi3_intbus_bridge;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [11:0] awid;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic [11:0] wid;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [11:0] bid;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [11:0] arid;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [11:0] rid;
   logic        rlast;
   logic [15:0] int_addr;
   logic [31:0] int_wdata;
   logic        int_wr, int_rd;
   logic [31:0] int_rdata;

   axi3_intbus_bridge #(.ADDR_WIDTH(16), .ID_WIDTH(12)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wid(wid),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rid(rid), .rlast(rlast),
      .int_addr(int_addr), .int_wdata(int_wdata), .int_wr(int_wr),
      .int_rd(int_rd), .int_rdata(int_rdata)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
   typedef struct packed {logic [31:0] d; logic [11:0] id; logic last;} r_t;

   wr_t         exp_wr[$];
   logic [15:0] exp_rd[$];
   logic [11:0] exp_b[$];
   r_t          exp_r[$];
   wr_t         mw;
   logic [15:0] mrd;
   logic [11:0] mb;
   r_t          mr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_b_cyc = 0;
   int last_ar_cyc = 0;

   // Register-slave contents: one distinctive word, elsewhere the address tagged with D00D.
   function automatic logic [31:0] slave_val(input logic [15:0] a);
      return (a == 16'h0004) ? 32'hA1B2C3D4 : {16'hD00D, a};
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // Slave answers exactly one cycle after int_rd; otherwise drives garbage.
   always @(posedge aclk) int_rdata <= int_rd ? slave_val(int_addr) : 32'hDEADBEEF;

   task automatic bound_check(input string what, input bit ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: no handshake within 100 cycles", what);
      end
   endtask

   // Monitor: every DUT output event is matched against the head of its queue.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (int_wr || (wvalid && wready)) begin
            checks++;
            if (int_wr !== (wvalid && wready) || int_rd) begin
               errors++;
               $display("FAIL wr_strobe: int_wr=%0b int_rd=%0b w_handshake=%0b", int_wr, int_rd, wvalid && wready);
            end
         end
         if (int_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL int_wr_unexpected: addr=%h data=%h, none required", int_addr, int_wdata);
            end else begin
               mw = exp_wr.pop_front();
               if (int_addr !== mw.a || int_wdata !== mw.d) begin
                  errors++;
                  $display("FAIL int_wr: addr=%h data=%h, required addr=%h data=%h", int_addr, int_wdata, mw.a, mw.d);
               end
            end
         end
         if (int_rd) begin
            checks++;
            if (exp_rd.size() == 0) begin
               errors++;
               $display("FAIL int_rd_unexpected: addr=%h, none required", int_addr);
            end else begin
               mrd = exp_rd.pop_front();
               if (int_addr !== mrd) begin
                  errors++;
                  $display("FAIL int_rd: addr=%h, required %h", int_addr, mrd);
               end
            end
         end
         if (bvalid && bready) begin
            checks++;
            if (exp_b.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected: bid=%h, none required", bid);
            end else begin
               mb = exp_b.pop_front();
               if (bid !== mb || bresp !== 2'b00) begin
                  errors++;
                  $display("FAIL b_resp: bid=%h bresp=%0d, required bid=%h bresp=0", bid, bresp, mb);
               end
            end
         end
         if (rvalid && rready) begin
            checks++;
            if (exp_r.size() == 0) begin
               errors++;
               $display("FAIL r_unexpected: rdata=%h rid=%h, none required", rdata, rid);
            end else begin
               mr = exp_r.pop_front();
               if (rdata !== mr.d || rid !== mr.id || rlast !== mr.last || rresp !== 2'b00) begin
                  errors++;
                  $display("FAIL r_beat: rdata=%h rid=%h rlast=%0b rresp=%0d, required rdata=%h rid=%h rlast=%0b rresp=0",
                           rdata, rid, rlast, rresp, mr.d, mr.id, mr.last);
               end
            end
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                           input logic [31:0] d0, input logic [31:0] d1, input int wgap,
                           input int bdelay, input bit good_wlast);
      logic [15:0] wa;
      wr_t         e;
      int          n;
      wa = addr[17:2];
      for (int i = 0; i <= int'(len); i++) begin
         e.a = wa + 16'(i);
         e.d = (i == 0) ? d0 : d1;
         exp_wr.push_back(e);
      end
      exp_b.push_back(id);
      awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b00;
      n = 0;
      do begin @(negedge aclk); n++; end while (!awready && n < 100);
      bound_check("aw_handshake", awready);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      repeat (wgap) begin @(posedge aclk); #1; end
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1; wdata = (i == 0) ? d0 : d1; wid = id; wstrb = 4'h3;
         wlast = good_wlast && (i == int'(len));
         n = 0;
         do begin @(negedge aclk); n++; end while (!wready && n < 100);
         bound_check("w_handshake", wready);
         @(posedge aclk); #1;
         wvalid = 1'b0; wlast = 1'b0;
      end
      n = 0;
      do begin @(negedge aclk); n++; end while (!bvalid && n < 100);
      bound_check("b_valid", bvalid);
      for (int k = 0; k < bdelay; k++) begin
         checks++;
         if (bvalid !== 1'b1 || bid !== id) begin
            errors++;
            $display("FAIL b_hold: bvalid=%0b bid=%h, required bvalid=1 bid=%h", bvalid, bid, id);
         end
         @(posedge aclk); #1;
         @(negedge aclk);
      end
      @(posedge aclk); #1;
      bready = 1'b1;
      @(negedge aclk);
      last_b_cyc = cyc;
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len,
                          input int stall, input bit chk_lat);
      logic [15:0] wa;
      r_t          e;
      int          n;
      int          c0;
      wa = addr[17:2];
      for (int i = 0; i <= int'(len); i++) begin
         exp_rd.push_back(wa + 16'(i));
         e.d = slave_val(wa + 16'(i)); e.id = id; e.last = (i == int'(len));
         exp_r.push_back(e);
      end
      arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b10;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < 100);
      bound_check("ar_handshake", arready);
      c0 = cyc;
      last_ar_cyc = cyc;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         n = 0;
         do begin @(negedge aclk); n++; end while (!rvalid && n < 100);
         bound_check("r_valid", rvalid);
         if (chk_lat && i == 0) begin
            checks++;
            if (cyc - c0 != 3) begin
               errors++;
               $display("FAIL rd_latency: %0d cycles from AR to rvalid, required 3", cyc - c0);
            end
         end
         for (int k = 0; k < stall; k++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== slave_val(wa + 16'(i))) begin
               errors++;
               $display("FAIL r_stall: rvalid=%0b rdata=%h, required rvalid=1 rdata=%h", rvalid, rdata, slave_val(wa + 16'(i)));
            end
            @(posedge aclk); #1;
            @(negedge aclk);
         end
         @(posedge aclk); #1;
         rready = 1'b1;
         @(negedge aclk);
         @(posedge aclk); #1;
         rready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int rv_seen;
      aresetn = 1'b0;
      awvalid = 1'b0; awaddr = 32'd0; awid = 12'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0;
      wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wid = 12'd0;
      bready = 1'b0;
      arvalid = 1'b0; araddr = 32'd0; arid = 12'd0; arlen = 4'd0; arsize = 3'd0; arburst = 2'd0;
      rready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast, int_wr, int_rd} !== 8'd0 ||
          int_addr !== 16'd0 || rdata !== 32'd0 || bid !== 12'd0 || rid !== 12'd0) begin
         errors++;
         $display("FAIL reset_state: ctl=%b addr=%h rdata=%h bid=%h rid=%h, required all 0",
                  {awready, arready, wready, bvalid, rvalid, rlast, int_wr, int_rd}, int_addr, rdata, bid, rid);
      end
      aresetn = 1'b1;
      @(posedge aclk); #1;

      do_read(32'h0000_0010, 12'h000, 4'd0, 0, 1'b1);
      do_write(32'h0000_0020, 12'h005, 4'd0, 32'h1234_5678, 32'h0, 0, 4, 1'b1);

      fork
         do_write(32'h0000_0030, 12'h007, 4'd0, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b1);
         do_read(32'h0000_0044, 12'h003, 4'd0, 0, 1'b0);
      join
      checks++;
      if (last_ar_cyc <= last_b_cyc) begin
         errors++;
         $display("FAIL wr_priority: arready at cycle %0d, required after B at cycle %0d", last_ar_cyc, last_b_cyc);
      end

      do_read(32'h0000_0040, 12'h009, 4'd3, 2, 1'b0);

      // Reset while the read sits in RD_WAIT: only its int_rd is expected.
      exp_rd.push_back(16'h0014);
      arvalid = 1'b1; araddr = 32'h0000_0050; arid = 12'h004; arlen = 4'd0;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < 100);
      bound_check("ar_handshake_rst", arready);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      n = 0;
      do begin @(negedge aclk); n++; end while (!int_rd && n < 100);
      bound_check("int_rd_rst", int_rd);
      @(posedge aclk); #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast, int_wr, int_rd} !== 8'd0 ||
          int_addr !== 16'd0 || rdata !== 32'd0 || rid !== 12'd0) begin
         errors++;
         $display("FAIL mid_reset: ctl=%b addr=%h rdata=%h rid=%h, required all 0",
                  {awready, arready, wready, bvalid, rvalid, rlast, int_wr, int_rd}, int_addr, rdata, rid);
      end
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      rready = 1'b1;
      rv_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         if (rvalid) rv_seen++;
      end
      checks++;
      if (rv_seen != 0) begin
         errors++;
         $display("FAIL post_reset_r: %0d rvalid cycles after release, required 0", rv_seen);
      end
      @(posedge aclk); #1;
      rready = 1'b0;

      do_read(32'h0000_0010, 12'h001, 4'd0, 1, 1'b1);
      do_write(32'h0000_0100, 12'h002, 4'd1, 32'h1111_1111, 32'h2222_2222, 5, 0, 1'b1);
      do_write(32'hFFFC_0008, 12'hABC, 4'd0, 32'h5A5A_A5A5, 32'h0, 0, 1, 1'b0);
      do_read(32'h8000_0010, 12'hFFF, 4'd0, 0, 1'b1);

      repeat (5) @(posedge aclk);
      #1;
      checks++;
      if (exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size() != 0) begin
         errors++;
         $display("FAIL leftover: wr=%0d rd=%0d b=%0d r=%0d events never seen, required 0",
                  exp_wr.size(), exp_rd.size(), exp_b.size(), exp_r.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
